// File: rtl/data_ram_if.sv
// Load/store request and response bundle for data_ram; master drives requests, slave returns responses.
interface data_ram_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [WIDTH-1:0]  rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, address, wdata,
    input  req_ready, rsp_valid, rsp_err, rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, address, wdata,
    output req_ready, rsp_valid, rsp_err, rdata
  );
endinterface

// File: rtl/data_ram.sv
// Byte-lane data memory with sized, extended loads; DATA_RAM_CLEAR_EN adds a post-reset zeroing scrub.
// Latency 1 for loads and stores; req_ready is low during RESET/CLEAR, otherwise one request per cycle.
module data_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       nrst,
  data_ram_if.slave  bus
);
  localparam int LANES = WIDTH / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

`ifdef DATA_RAM_CLEAR_EN
  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_IDLE} state_t;
`else
  typedef enum logic [1:0] {ST_RESET, ST_IDLE} state_t;
`endif

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] align_mask;
  logic [LANES-1:0] base_mask;
  logic [LANES-1:0] lane_en;
  logic [WIDTH-1:0] keep_mask;
  logic [WIDTH-1:0] wr_shift;
  logic [WIDTH-1:0] rd_shift;
  logic [WIDTH-1:0] rd_ext;
  logic             sign_bit;
  logic             size_err;
  logic             misalign;
  logic             err;

  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] rdata_q;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.address[ADDR_W-1:IDX_W+OFF_W];

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef DATA_RAM_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: begin
`ifdef DATA_RAM_CLEAR_EN
        state_nxt = ST_CLEAR;
`else
        state_nxt = ST_IDLE;
`endif
      end
`ifdef DATA_RAM_CLEAR_EN
      ST_CLEAR: begin
        if (clr_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      ST_IDLE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  // ---------------------------------------------------------------- request decode
  assign idx = bus.address[IDX_W+OFF_W-1:OFF_W];
  assign off = bus.address[OFF_W-1:0];

  always_comb begin
    base_mask  = '0;
    align_mask = '0;
    case (bus.req_size)
      2'b00: begin
        base_mask  = LANES'(8'h01);
        align_mask = '0;
      end
      2'b01: begin
        base_mask  = LANES'(8'h03);
        align_mask = OFF_W'(1);
      end
      2'b10: begin
        base_mask  = LANES'(8'h0F);
        align_mask = OFF_W'(3);
      end
      default: begin
        base_mask  = LANES'(8'hFF);
        align_mask = OFF_W'(7);
      end
    endcase
  end

  assign size_err = (bus.req_size == 2'b11) && (WIDTH == 32);
  assign misalign = |(off & align_mask);
  assign err      = size_err || misalign;
  assign lane_en  = base_mask << off;
  assign wr_shift = bus.wdata << {off, 3'b000};

  // ---------------------------------------------------------------- load alignment and extension
  assign rd_shift = mem[idx] >> {off, 3'b000};

  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_mask[8*i +: 8] = {8{base_mask[i]}};
    end
  end

  always_comb begin
    sign_bit = 1'b0;
    case (bus.req_size)
      2'b00:   sign_bit = rd_shift[7];
      2'b01:   sign_bit = rd_shift[15];
      2'b10:   sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[WIDTH-1];
    endcase
  end

  // Bits outside the access width are filled with the sign; full-width accesses pass through since keep_mask is all ones.
  assign rd_ext = (rd_shift & keep_mask) |
                  ({WIDTH{sign_bit && !bus.req_unsigned}} & ~keep_mask);

  // ---------------------------------------------------------------- storage
  always_ff @(posedge clk) begin
`ifdef DATA_RAM_CLEAR_EN
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else
`endif
    if (accept && bus.req_write && !err) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem[idx][8*i +: 8] <= wr_shift[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- response
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q <= err;
        rdata_q   <= (err || bus.req_write) ? '0 : rd_ext;
      end else begin
        rsp_err_q <= 1'b0;
        rdata_q   <= '0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: doc/data_ram.md
# data_ram

Synchronous single-port data memory for the RISC-V core's load/store path, the parametrised successor to the plain word RAM. It adds byte/halfword/word (and doubleword at WIDTH=64) access with byte-lane write merging and a valid/ready request handshake. Read data is registered, sign- or zero-extended, and flagged on misalignment. An optional post-reset scrub FSM zeroes the array before the first request is accepted.

## Interface
- WIDTH, 32, data word width; legal values 32 or 64; LANES = WIDTH/8
- DEPTH, 2048, number of WIDTH-bit words; power of two, ≥ 2
- ADDR_W, 32, byte-address width
- clk  input  1  clock; all state changes on rising edge
- nrst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword (WIDTH=64 only)
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- address  input  ADDR_W  byte address
- wdata  input  WIDTH  store data, right-aligned (LSBs)
- rsp_valid  output  1  one-cycle response pulse
- rsp_err  output  1  request was misaligned or used an illegal size; qualified by rsp_valid
- rdata  output  WIDTH  extended load data; qualified by rsp_valid

## Operation
- Word index = address[$clog2(DEPTH)+$clog2(LANES)-1 : $clog2(LANES)]. Higher address bits are ignored, so the array wraps. Byte offset = address[$clog2(LANES)-1:0].
- A request is accepted on a rising edge where req_valid && req_ready.
- Misaligned means the offset is not a multiple of 2^req_size. size 11 is illegal at WIDTH=32. An erroneous request is accepted, writes nothing, and returns rsp_err=1 with rdata=0.
- Store: only the lanes selected by size and offset are written, each taking the matching byte of wdata shifted to the offset. All other lanes keep their value. The store returns rsp_valid with rsp_err=0 and rdata=0.
- Load: the selected lanes are shifted down to bit 0, then extended to WIDTH per req_unsigned. A word load at WIDTH=32 is passed through unchanged.
- FSM states:
  - RESET→CLEAR when DATA_RAM_CLEAR_EN is defined, else RESET→IDLE.
  - CLEAR writes 0 to word clr_cnt each cycle, counting 0..DEPTH-1, then moves to IDLE. req_ready=0 throughout.
  - IDLE: req_ready=1, no stall. Throughput is one request per cycle.
- Memory has no reset. Only the control registers reset.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rdata=0, state=RESET, clr_cnt=0.
- The first cycle after nrst deasserts is RESET, then CLEAR or IDLE. Without the macro, req_ready=1 on the second edge after release.
- Load latency is 1. Accept at edge N gives rsp_valid=1 and rdata valid after edge N, held until edge N+1.
- Store latency is 1. The array updates at edge N, and the ack is rsp_valid after edge N.
- Back-to-back: a store at edge N followed by a load of the same word at edge N+1 returns the new data.
- rsp_valid drops after one cycle when no request is accepted.
- Reset asserted mid-CLEAR aborts the scrub. clr_cnt returns to 0 and the scrub restarts from word 0 after release.
- Reset asserted with a response pending clears rsp_valid immediately (asynchronous). The lost response is not replayed.

## Configuration
- DATA_RAM_CLEAR_EN defined: the CLEAR scrub runs after every reset. The ready latency is DEPTH+1 cycles after release, and every word reads 0 until written.
- DATA_RAM_CLEAR_EN undefined: the CLEAR state and clr_cnt are not built. The block is ready after one cycle, and the array contents are undefined until written.

## Test plan
- Scrub (macro on, DEPTH=16): release nrst, count edges until req_ready=1 → exactly 17. A word load of 0x24 then returns 0x00000000.
- Lane merge (WIDTH=32): store word 0x11223344 to 0x40, then store byte 0xAA to 0x42, then load word 0x40 → 0x11AA3344, rsp_err=0.
- Extension: with word 0x40 = 0x0000_80FF:
  - signed half load at 0x40 → 0xFFFF80FF
  - unsigned half load at 0x40 → 0x000080FF
  - signed byte load at 0x41 → 0xFFFFFF80
- Misalignment: word store at 0x42 with wdata 0xDEADBEEF → rsp_err=1, rdata=0. A following word load of 0x40 is unchanged. A half load at 0x43 also gives rsp_err=1.
- Throughput/wrap (DEPTH=16): issue 4 stores on consecutive edges to 0x00, 0x04, 0x40, 0x44 with data 1..4. rsp_valid stays high for 4 cycles. Loads of 0x00 and 0x04 then return 3 and 4.
- Reset mid-operation: assert nrst during CLEAR at clr_cnt=5 and during a pending load → rsp_valid=0 and req_ready=0 immediately. After release the full DEPTH+1 cycle scrub repeats.
